// File: rtl/calc_pkg.sv
// Shared definitions for the AXI4-Lite calculator register bank and its alu.
package calc_pkg;

    // Calculator opcodes held in CTRL[2:0]
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_AND     = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_LOAD_A  = 3'b011;
    localparam logic [2:0] OP_M_PLUS  = 3'b100;
    localparam logic [2:0] OP_M_MINUS = 3'b101;
    localparam logic [2:0] OP_MR      = 3'b110;
    localparam logic [2:0] OP_MC      = 3'b111;

    // Register byte offsets
    localparam logic [4:0] OFF_OPA    = 5'h00;
    localparam logic [4:0] OFF_OPB    = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_RESULT = 5'h0C;
    localparam logic [4:0] OFF_MEM    = 5'h10;

    // Word indices as decoded from address bits [4:2]
    localparam logic [2:0] IDX_OPA    = OFF_OPA[4:2];
    localparam logic [2:0] IDX_OPB    = OFF_OPB[4:2];
    localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_RESULT = OFF_RESULT[4:2];
    localparam logic [2:0] IDX_MEM    = OFF_MEM[4:2];

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // True when a decoded word index maps onto an implemented register
    function automatic logic idx_valid(input logic [2:0] idx);
        return idx <= IDX_MEM;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit alu: ADD (carry dropped), AND, XOR; other opcodes yield 0.
module alu
    import calc_pkg::*;
(
    input  logic [7:0] operand_a,
    input  logic [7:0] operand_b,
    input  logic [2:0] opcode,
    output logic [7:0] result
);

    // Opcode decode into the arithmetic/logic result
    always_comb begin
        // NOTE: default assignment first so no path leaves result unassigned (no latch).
        result = '0;
        case (opcode)
            OP_ADD:  result = operand_a + operand_b;
            OP_AND:  result = operand_a & operand_b;
            OP_XOR:  result = operand_a ^ operand_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/axi_lite_calc_regs.sv
// AXI4-Lite responder holding the calculator registers; executes register-bank
// ops itself and uses the alu for ADD/AND/XOR.
module axi_lite_calc_regs
    import calc_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);

    wstate_t    wstate;
    rstate_t    rstate;

    logic       aw_held;
    logic       w_held;
    logic [2:0] aw_idx;
    logic [7:0] wdata_q;
    logic       wstrb_q;

    logic [7:0] opa;
    logic [7:0] opb;
    logic [2:0] ctrl;
    logic [7:0] result;
    logic [7:0] mem;
    logic [7:0] alu_result;

    logic       aw_hs;
    logic       w_hs;
    logic       commit;
    logic [2:0] cur_idx;
    logic [7:0] cur_data;
    logic       cur_strb;

    logic [2:0] rd_idx;
    logic [7:0] rd_val;
    logic       rd_err;

    // Address bits [1:0], upper data bits and upper strobes carry no meaning here.
    logic       unused_bits;
    assign unused_bits = ^{awaddr, araddr, wdata, wstrb};

    alu u_alu (
        .operand_a (opa),
        .operand_b (opb),
        .opcode    (ctrl),
        .result    (alu_result)
    );

    // A channel's payload is taken from the holding register once captured,
    // otherwise straight from the bus on the cycle it handshakes.
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign commit   = (aw_held || aw_hs) && (w_held || w_hs);
    assign cur_idx  = aw_held ? aw_idx  : awaddr[4:2];
    assign cur_data = w_held  ? wdata_q : wdata[7:0];
    assign cur_strb = w_held  ? wstrb_q : wstrb[0];

    // Write FSM: collect AW and W in any order, commit, optionally execute, respond
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= AXI_RESP_OKAY;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            wdata_q <= '0;
            wstrb_q <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            ctrl    <= '0;
            result  <= '0;
            mem     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (wstate)
                W_IDLE: begin
                    if (commit) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        if (cur_strb) begin
                            case (cur_idx)
                                IDX_OPA:  opa  <= cur_data;
                                IDX_OPB:  opb  <= cur_data;
                                IDX_CTRL: ctrl <= cur_data[2:0];
                                default:  ;
                            endcase
                        end
                        if (cur_idx == IDX_CTRL) begin
                            wstate <= W_EXEC;
                        end else begin
                            wstate <= W_RESP;
                            bvalid <= 1'b1;
                            bresp  <= idx_valid(cur_idx) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held <= 1'b1;
                            aw_idx  <= awaddr[4:2];
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            wdata_q <= wdata[7:0];
                            wstrb_q <= wstrb[0];
                        end
                        awready <= !(aw_held || aw_hs);
                        wready  <= !(w_held || w_hs);
                    end
                end
                W_EXEC: begin
                    case (ctrl)
                        OP_ADD, OP_AND, OP_XOR: result <= alu_result;
                        OP_LOAD_A:              opa    <= mem;
                        OP_M_PLUS:              mem    <= mem + result;
                        OP_M_MINUS:             mem    <= mem - result;
                        OP_MR:                  result <= mem;
                        OP_MC:                  mem    <= '0;
                        default:                ;
                    endcase
                    wstate <= W_RESP;
                    bvalid <= 1'b1;
                    bresp  <= AXI_RESP_OKAY;
                end
                W_RESP: begin
                    if (bready) begin
                        wstate  <= W_IDLE;
                        bvalid  <= 1'b0;
                        bresp   <= AXI_RESP_OKAY;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read decode of the current register contents
    assign rd_idx = araddr[4:2];

    // Read mux: implemented registers return their value, anything else 0 with an error
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        case (rd_idx)
            IDX_OPA:    rd_val = opa;
            IDX_OPB:    rd_val = opb;
            IDX_CTRL:   rd_val = {5'b00000, ctrl};
            IDX_RESULT: rd_val = result;
            IDX_MEM:    rd_val = mem;
            default:    rd_err = 1'b1;
        endcase
    end

    // Read FSM: accept AR, register data and response, hold until rready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= AXI_RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rstate  <= R_DATA;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rdata   <= {{(DATA_W-8){1'b0}}, rd_val};
                        rresp   <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rstate  <= R_IDLE;
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_calc_regs.sv
// Self-checking bench for axi_lite_calc_regs: directed scenarios followed by
// randomized traffic, all compared against a register-level reference model.
module tb_axi_lite_calc_regs;
    import calc_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [ADDR_W-1:0] araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    int m_opa, m_opb, m_ctrl, m_result, m_mem;

    axi_lite_calc_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_opa = 0; m_opb = 0; m_ctrl = 0; m_result = 0; m_mem = 0;
    endfunction

    // Architectural effect of one write; returns the response and the cycle,
    // counted from the last handshake cycle, in which bvalid must appear.
    function automatic void model_write(input logic [4:0] addr, input logic [31:0] data,
                                        input logic strb, output logic [1:0] resp,
                                        output int lat);
        int idx;
        idx  = int'(addr) / 4;
        resp = (idx <= 4) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        lat  = (idx == 2) ? 2 : 1;
        if (strb) begin
            if (idx == 0) m_opa = int'(data) & 255;
            if (idx == 1) m_opb = int'(data) & 255;
            if (idx == 2) m_ctrl = int'(data) & 7;
        end
        if (idx == 2) begin
            case (m_ctrl)
                int'(OP_ADD):     m_result = (m_opa + m_opb) % 256;
                int'(OP_AND):     m_result = m_opa & m_opb;
                int'(OP_XOR):     m_result = m_opa ^ m_opb;
                int'(OP_LOAD_A):  m_opa = m_mem;
                int'(OP_M_PLUS):  m_mem = (m_mem + m_result) % 256;
                int'(OP_M_MINUS): m_mem = (m_mem - m_result + 256) % 256;
                int'(OP_MR):      m_result = m_mem;
                default:          m_mem = 0;
            endcase
        end
    endfunction

    function automatic void model_read(input logic [4:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        int idx;
        idx  = int'(addr) / 4;
        resp = AXI_RESP_OKAY;
        case (idx)
            0: data = m_opa;
            1: data = m_opb;
            2: data = m_ctrl;
            3: data = m_result;
            4: data = m_mem;
            default: begin data = 0; resp = AXI_RESP_SLVERR; end
        endcase
    endfunction

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    // hold: cycles bready stays low once bvalid is seen.
    task automatic axi_write(input string tag, input logic [4:0] addr, input logic [31:0] data,
                             input logic strb, input int lead, input int hold);
        logic [1:0] exp_resp;
        int exp_lat;
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc, k;
        model_write(addr, data, strb, exp_resp, exp_lat);
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = addr; wdata = data; wstrb = {3'b000, strb};
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && (cyc >= ((lead > 0) ? lead : 0));
            wvalid  = !w_done  && (cyc >= ((lead < 0) ? -lead : 0));
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, " handshakes"}, {30'd0, aw_done, w_done}, 32'd3);
        k = 1;
        while (!bvalid && k < 8) begin
            @(posedge aclk); #1;
            k++;
        end
        check({tag, " bvalid latency"}, k, exp_lat);
        check({tag, " bresp"}, bresp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            check({tag, " bvalid held"}, bvalid, 1'b1);
            check({tag, " bresp held"}, bresp, exp_resp);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check({tag, " bvalid drops"}, bvalid, 1'b0);
        check({tag, " awready next"}, awready, 1'b1);
    endtask

    task automatic axi_read(input string tag, input logic [4:0] addr, input int hold);
        logic [31:0] exp_data;
        logic [1:0] exp_resp;
        int cyc;
        model_read(addr, exp_data, exp_resp);
        araddr = addr; arvalid = 1'b1; cyc = 0;
        while (!arready && cyc < 50) begin
            @(posedge aclk); #1;
            cyc++;
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check({tag, " rvalid"}, rvalid, 1'b1);
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " rresp"}, rresp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            check({tag, " rvalid held"}, rvalid, 1'b1);
            check({tag, " rdata held"}, rdata, exp_data);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check({tag, " rvalid drops"}, rvalid, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " ctl outputs"},
              {24'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp[0]}, 32'd0);
        check({tag, " rresp"}, rresp, 2'b00);
        check({tag, " rdata"}, rdata, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [4:0] a;
        model_reset();

        // Reset state
        #2;
        check_outputs_zero("reset");
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int i = 0; i < 5; i++) axi_read("reset regs", 5'(i * 4), 0);

        // 1: ADD with wrap
        axi_write("t1 opa", OFF_OPA, 32'hF0, 1'b1, 0, 0);
        axi_write("t1 opb", OFF_OPB, 32'h20, 1'b1, 0, 0);
        axi_write("t1 ctrl", OFF_CTRL, 32'(OP_ADD), 1'b1, 0, 0);
        axi_read("t1 result", OFF_RESULT, 0);
        check("t1 result literal", rdata, 32'h10);

        // 2: memory accumulate
        axi_write("t2 m+", OFF_CTRL, 32'(OP_M_PLUS), 1'b1, 0, 0);
        axi_write("t2 m+", OFF_CTRL, 32'(OP_M_PLUS), 1'b1, 0, 0);
        axi_read("t2 mem", OFF_MEM, 0);
        check("t2 mem literal", rdata, 32'h20);
        axi_write("t2 m-", OFF_CTRL, 32'(OP_M_MINUS), 1'b1, 0, 0);
        axi_read("t2 mem", OFF_MEM, 0);
        check("t2 mem2 literal", rdata, 32'h10);

        // 3: LOAD_A, MC, MR
        axi_write("t3 load_a", OFF_CTRL, 32'(OP_LOAD_A), 1'b1, 0, 0);
        axi_read("t3 opa", OFF_OPA, 0);
        check("t3 opa literal", rdata, 32'h10);
        axi_write("t3 mc", OFF_CTRL, 32'(OP_MC), 1'b1, 0, 0);
        axi_read("t3 mem", OFF_MEM, 0);
        axi_write("t3 mr", OFF_CTRL, 32'(OP_MR), 1'b1, 0, 0);
        axi_read("t3 result", OFF_RESULT, 0);
        check("t3 result literal", rdata, 32'h00);

        // 4: channel ordering and strobe
        axi_write("t4 w first", OFF_OPB, 32'hFFFF_FF3C, 1'b1, 3, 0);
        axi_read("t4 opb", OFF_OPB, 0);
        axi_write("t4 together", OFF_OPA, 32'h77, 1'b1, 0, 0);
        axi_read("t4 opa", OFF_OPA, 0);
        axi_write("t4 strb0", OFF_OPB, 32'hAA, 1'b0, 0, 0);
        axi_read("t4 opb kept", OFF_OPB, 0);
        check("t4 opb literal", rdata, 32'h3C);

        // 5: unmapped offsets with back-pressure
        axi_write("t5 bad wr", 5'h18, 32'h5A, 1'b1, 0, 5);
        axi_read("t5 bad rd", 5'h1C, 5);
        check("t5 slverr literal", {30'd0, rresp}, 32'(AXI_RESP_SLVERR));

        // 6a: reset while in W_EXEC
        awaddr = OFF_CTRL; wdata = 32'(OP_ADD); wstrb = 4'h1;
        awvalid = 1'b1; wvalid = 1'b1; cyc = 0;
        while (!(awready && wready) && cyc < 20) begin
            @(posedge aclk); #1;
            cyc++;
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("t6 in exec bvalid", bvalid, 1'b0);
        aresetn = 1'b0;
        #1;
        model_reset();
        check_outputs_zero("t6 exec reset");
        @(posedge aclk); #1 aresetn = 1'b1;
        for (int i = 0; i < 5; i++) axi_read("t6 regs", 5'(i * 4), 0);
        axi_write("t6 after", OFF_OPA, 32'h33, 1'b1, 0, 0);

        // 6b: reset while in R_DATA
        araddr = OFF_OPA; arvalid = 1'b1; cyc = 0;
        while (!arready && cyc < 20) begin
            @(posedge aclk); #1;
            cyc++;
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("t6 rdata pre", rdata, 32'h33);
        aresetn = 1'b0;
        #1;
        model_reset();
        check_outputs_zero("t6 rdata reset");
        @(posedge aclk); #1 aresetn = 1'b1;
        axi_read("t6 opa cleared", OFF_OPA, 0);
        axi_write("t6 after2", OFF_OPB, 32'h44, 1'b1, -1, 0);
        axi_read("t6 opb", OFF_OPB, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            a = 5'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 2) == 0) a = OFF_CTRL;
            axi_write("rnd wr", a, $urandom, ($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 1)));
            axi_read("rnd rd", 5'($urandom_range(0, 7) * 4), int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
